// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, req/ack instruction-memory port, instruction
// register with field decode, +4 / BEQ-target PC update on retire, and a
// sticky trap on unsupported opcodes.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_FETCH   | imem_req high at pc, waiting for imem_ack to load IR
// ST_HOLD    | IR valid, waiting for the consumer to retire it
// ST_TRAP    | unsupported opcode seen; frozen until reset
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_taken,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  funct,
  output logic [31:0] imm_sext,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        illegal,
  output logic [31:0] retired_cnt
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_TRAP  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] retired_cnt_q, retired_cnt_d;
  logic        opcode_legal;
  logic [31:0] branch_target;

  // Field split and PC arithmetic, all combinational from IR / pc
  always_comb begin
    instr         = ir_q;
    opcode        = ir_q[31:26];
    rs            = ir_q[25:21];
    rt            = ir_q[20:16];
    rd            = ir_q[15:11];
    funct         = ir_q[5:0];
    imm_sext      = {{16{ir_q[15]}}, ir_q[15:0]};
    pc            = pc_q;
    pc_plus4      = pc_q + 32'd4;
    branch_target = pc_plus4 + {imm_sext[29:0], 2'b00};
    retired_cnt   = retired_cnt_q;
    illegal       = (state_q == ST_TRAP);
    instr_valid   = (state_q == ST_HOLD);
    // Request is suppressed while reset is high so an in-flight fetch is dropped at once
    imem_req      = (state_q == ST_FETCH) && !reset;
    imem_addr     = pc_q;
  end

  // Supported opcodes: R-type, addi, lw, sw, beq
  always_comb begin
    opcode_legal = 1'b0;
    case (imem_rdata[31:26])
      6'b000000, 6'b001000, 6'b100011, 6'b101011, 6'b000100: opcode_legal = 1'b1;
      default: opcode_legal = 1'b0;
    endcase
  end

  // Next-state logic for the fetch/hold/trap controller
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    retired_cnt_d = retired_cnt_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = opcode_legal ? ST_HOLD : ST_TRAP;
        end
      end
      ST_HOLD: begin
        // branch_taken only matters in the retire cycle
        if (instr_ready) begin
          retired_cnt_d = retired_cnt_q + 32'd1;
          pc_d          = branch_taken ? branch_target : pc_plus4;
          state_d       = ST_FETCH;
        end
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_TRAP;
      end
    endcase
  end

  // Register update with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_PC;
      ir_q          <= 32'd0;
      retired_cnt_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: the bench plays instruction memory
// and consumer, queues expected fetch addresses as it retires instructions,
// and compares them when the DUT raises its next request.
module tb_instr_fetch_unit;

  localparam logic [31:0] W_ADD  = 32'h0232_8020;
  localparam logic [31:0] W_BEQ  = 32'h1000_FFFE;
  localparam logic [31:0] W_BAD  = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_ready;
  logic        branch_taken;

  logic        imem_req, instr_valid, illegal;
  logic [31:0] imem_addr, instr, imm_sext, pc, pc_plus4, retired_cnt;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;

  logic        w_imem_req, w_instr_valid, w_illegal;
  logic [31:0] w_imem_addr, w_instr, w_imm_sext, w_pc, w_pc_plus4, w_retired_cnt;
  logic [5:0]  w_opcode, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] addr_q[$];
  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .branch_taken(branch_taken),
    .instr(instr), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .funct(funct),
    .imm_sext(imm_sext), .pc(pc), .pc_plus4(pc_plus4), .illegal(illegal),
    .retired_cnt(retired_cnt)
  );

  // Second copy starting at the top of the address space, fed the same stimulus
  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(w_instr_valid), .instr_ready(instr_ready), .branch_taken(branch_taken),
    .instr(w_instr), .opcode(w_opcode), .rs(w_rs), .rt(w_rt), .rd(w_rd), .funct(w_funct),
    .imm_sext(w_imm_sext), .pc(w_pc), .pc_plus4(w_pc_plus4), .illegal(w_illegal),
    .retired_cnt(w_retired_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fetch_addr();
    logic [31:0] a;
    chk("addr_q_nonempty", 32'(addr_q.size() != 0), 32'd1);
    if (addr_q.size() != 0) begin
      a = addr_q.pop_front();
      chk("imem_addr", imem_addr, a);
    end
  endtask

  // One fetch + retire; entered at a sample point with the DUT in FETCH
  task automatic do_instr(input logic [31:0] word, input int ack_wait,
                          input int ready_wait, input logic tk);
    int req_cycles;
    logic [31:0] nxt;
    req_cycles = 0;
    for (int i = 0; i < ack_wait; i++) begin
      imem_ack = 1'b0;
      #1;
      if (imem_req) req_cycles++;
      step();
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    #1;
    if (imem_req) req_cycles++;
    check_fetch_addr();
    step();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    chk("req_cycles", 32'(req_cycles), 32'(ack_wait + 1));
    chk("instr_valid", {31'd0, instr_valid}, 32'd1);
    chk("instr", instr, word);
    chk("req_in_hold", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < ready_wait; i++) begin
      instr_ready  = 1'b0;
      branch_taken = i[0];
      imem_ack     = 1'b1;      // stray ack while not requesting
      imem_rdata   = W_BAD;
      step();
      chk("hold_instr", instr, word);
      chk("hold_pc", pc, exp_pc);
      chk("hold_req", {31'd0, imem_req}, 32'd0);
    end
    imem_ack     = 1'b0;
    instr_ready  = 1'b1;
    branch_taken = tk;
    nxt = exp_pc + 32'd4;
    if (tk) nxt = nxt + {{14{word[15]}}, word[15:0], 2'b00};
    addr_q.push_back(nxt);
    exp_cnt = exp_cnt + 32'd1;
    step();
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    exp_pc = nxt;
    chk("retired_cnt", retired_cnt, exp_cnt);
    chk("req_after_retire", {31'd0, imem_req}, 32'd1);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    chk("req_in_reset", {31'd0, imem_req}, 32'd0);
    step();
    reset    = 1'b0;
    imem_ack = 1'b0;
    #1;
    chk("rst_pc", pc, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_cnt", retired_cnt, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd1);
    addr_q.delete();
    addr_q.push_back(32'd0);
    exp_pc  = 32'd0;
    exp_cnt = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0;
    instr_ready = 1'b0; branch_taken = 1'b0;
    exp_pc = 32'd0; exp_cnt = 32'd0;
    step();
    apply_reset();

    // Straight-line adds with zero-wait ack
    chk("wrap_reset_addr", w_imem_addr, 32'hFFFF_FFFC);
    do_instr(W_ADD, 0, 0, 1'b0);
    chk("wrap_next_addr", w_imem_addr, 32'd0);
    chk("opcode", {26'd0, opcode}, 32'd0);
    chk("rs", {27'd0, rs}, 32'd17);
    chk("rt", {27'd0, rt}, 32'd18);
    chk("rd", {27'd0, rd}, 32'd16);
    chk("funct", {26'd0, funct}, 32'h20);
    do_instr(W_ADD, 0, 0, 1'b0);
    do_instr(W_ADD, 0, 0, 1'b0);
    do_instr(W_ADD, 0, 0, 1'b0);
    chk("pc_plus4", pc_plus4, 32'h14);

    // beq at 0x10: taken goes back to 0x0C, not taken goes to 0x14
    do_instr(W_BEQ, 0, 0, 1'b1);
    chk("imm_sext", imm_sext, 32'hFFFF_FFFE);
    chk("beq_taken_pc", pc, 32'h0C);
    do_instr(W_ADD, 0, 0, 1'b0);
    do_instr(W_BEQ, 0, 0, 1'b0);
    chk("beq_not_taken_pc", pc, 32'h14);

    // Slow memory and a stalled consumer with a wiggling branch_taken
    do_instr(W_BEQ, 3, 4, 1'b0);
    chk("stall_pc", pc, 32'h18);

    // Unsupported opcode traps until reset
    imem_ack = 1'b1; imem_rdata = W_BAD;
    #1;
    check_fetch_addr();
    step();
    for (int i = 0; i < 4; i++) begin
      imem_ack   = i[0];
      imem_rdata = W_ADD;
      chk("trap_illegal", {31'd0, illegal}, 32'd1);
      chk("trap_valid", {31'd0, instr_valid}, 32'd0);
      chk("trap_req", {31'd0, imem_req}, 32'd0);
      chk("trap_instr", instr, W_BAD);
      chk("trap_pc", pc, 32'h18);
      step();
    end
    apply_reset();

    // Reset while a fetch is waiting on ack; ack in the reset cycle is dropped
    do_instr(W_ADD, 0, 0, 1'b0);
    imem_ack = 1'b0;
    #1;
    check_fetch_addr();
    chk("wait_req", {31'd0, imem_req}, 32'd1);
    step();
    chk("wait_req2", {31'd0, imem_req}, 32'd1);
    imem_ack = 1'b1; imem_rdata = W_ADD;
    apply_reset();
    do_instr(W_ADD, 1, 1, 1'b0);
    chk("resume_pc", pc, 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
